// File: rtl/serial_pattern_pkg.sv
// Shared definitions for the serial bit-stream blocks: FSM state encoding
// and the parameter legality check every serial-stream block applies.
package serial_pattern_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      GAP   = 2'b10
   } state_t;

   function automatic bit paramsLegal(input int width, input int gap);
      return (width >= 2) && (gap >= 0);
   endfunction

endpackage

// File: rtl/serial_pattern_tx_if.sv
// Frame handshake and serial-output bundle between a pattern source and its user.
interface serial_pattern_tx_if #(
   parameter int WIDTH = 8
);

   logic             start;
   logic [WIDTH-1:0] data;
   logic             ready;
   logic             out;
   logic             busy;
   logic             last;

   modport master (output start, data, input ready, out, busy, last);
   modport slave  (input start, data, output ready, out, busy, last);

endinterface

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a captured WIDTH-bit frame out MSB first,
// then drives GAP zero bits before accepting the next frame.
module serial_pattern_tx
   import serial_pattern_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int GAP   = 2
) (
   input logic                clk,
   input logic                reset,
   serial_pattern_tx_if.slave bus
);

   localparam int BitCntW    = $clog2(WIDTH);
   localparam int GapCntW    = (GAP < 1) ? 1 : $clog2(GAP + 1);
   localparam int GapLastInt = (GAP > 0) ? GAP - 1 : 0;
   localparam logic [BitCntW-1:0] BitLast = BitCntW'(WIDTH - 1);
   localparam logic [GapCntW-1:0] GapLast = GapCntW'(GapLastInt);

   if (!paramsLegal(WIDTH, GAP)) begin : gBadParams
      $error("serial_pattern_tx: WIDTH must be >= 2 and GAP >= 0");
   end

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   shiftReg_q, shiftReg_d;
   logic [BitCntW-1:0] bitCnt_q, bitCnt_d;
   logic [GapCntW-1:0] gapCnt_q, gapCnt_d;

   // The local GAP parameter hides the enum literal, hence the scoped name.
   always_comb begin
      state_d    = state_q;
      shiftReg_d = shiftReg_q;
      bitCnt_d   = bitCnt_q;
      gapCnt_d   = gapCnt_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d    = SHIFT;
               shiftReg_d = bus.data;
               bitCnt_d   = '0;
            end
         end
         SHIFT: begin
            shiftReg_d = shiftReg_q << 1;
            if (bitCnt_q == BitLast) begin
               state_d  = (GAP > 0) ? serial_pattern_pkg::GAP : IDLE;
               gapCnt_d = '0;
            end else begin
               bitCnt_d = bitCnt_q + BitCntW'(1);
            end
         end
         serial_pattern_pkg::GAP: begin
            if (gapCnt_q == GapLast) begin
               state_d  = IDLE;
               gapCnt_d = '0;
            end else begin
               gapCnt_d = gapCnt_q + GapCntW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         shiftReg_q <= '0;
         bitCnt_q   <= '0;
         gapCnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         shiftReg_q <= shiftReg_d;
         bitCnt_q   <= bitCnt_d;
         gapCnt_q   <= gapCnt_d;
      end
   end

   // Outputs decode registered state only, so start/data never reach them combinationally.
   assign bus.ready = (state_q == IDLE);
   assign bus.busy  = (state_q == SHIFT) || (state_q == serial_pattern_pkg::GAP);
   assign bus.out   = (state_q == SHIFT) && shiftReg_q[WIDTH-1];
   assign bus.last  = (state_q == SHIFT) && (bitCnt_q == BitLast);

endmodule
